// File: rtl/memory_arbiter.sv
// Three-way arbiter that shares one memory map between CPU, video and keyboard.
// One access per two cycles: IDLE drives memory for the winner, ACK returns the pulse.
module memory_arbiter #(
  parameter int unsigned VID_MAX_WAIT = 4
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [14:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_ack,
  output logic [15:0] cpu_rdata,
  output logic        cpu_err,
  input  logic        vid_req,
  input  logic [12:0] vid_addr,
  output logic        vid_ack,
  output logic [15:0] vid_rdata,
  input  logic        kbd_valid,
  input  logic [15:0] kbd_code,
  output logic        kbd_ack,
  output logic [15:0] mem_in,
  output logic        mem_load,
  output logic [14:0] mem_address,
  input  logic [15:0] mem_out
);

  typedef enum logic {S_IDLE, S_ACK} state_e;
  typedef enum logic [1:0] {W_NONE, W_CPU, W_VID, W_KBD} win_e;

  localparam logic [3:0]  VMW     = 4'(VID_MAX_WAIT);
  localparam logic [14:0] KBD_REG = 15'h6000;

  state_e      state_q, state_d;
  win_e        win_q, win_d, win;
  logic        err_q, err_d;
  logic        last_cpu_q, last_cpu_d;
  logic [3:0]  vid_wait_q, vid_wait_d;
  logic [15:0] cpu_rdata_q, cpu_rdata_d;
  logic [15:0] vid_rdata_q, vid_rdata_d;
  logic        cpu_illegal, promoted;

  assign cpu_illegal = cpu_we && (cpu_addr >= KBD_REG);
  assign promoted    = (vid_wait_q >= VMW);
  assign cpu_rdata   = cpu_rdata_q;
  assign vid_rdata   = vid_rdata_q;

  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    err_d       = err_q;
    last_cpu_d  = last_cpu_q;
    vid_wait_d  = vid_wait_q;
    cpu_rdata_d = cpu_rdata_q;
    vid_rdata_d = vid_rdata_q;
    win         = W_NONE;
    mem_address = '0;
    mem_in      = '0;
    mem_load    = 1'b0;
    cpu_ack     = 1'b0;
    vid_ack     = 1'b0;
    kbd_ack     = 1'b0;
    cpu_err     = 1'b0;
    case (state_q)
      S_IDLE: begin
        // No grant while reset is held, so nothing reaches memory during reset.
        if (RST_N) begin
          if (promoted && vid_req)                         win = W_VID;
          else if (kbd_valid)                              win = W_KBD;
          else if (cpu_req && (!vid_req || !last_cpu_q))   win = W_CPU;
          else if (vid_req)                                win = W_VID;
        end
        case (win)
          W_CPU: begin
            mem_address = cpu_addr;
            mem_in      = cpu_wdata;
            mem_load    = cpu_we && !cpu_illegal;
            if (!cpu_we) cpu_rdata_d = mem_out;
            last_cpu_d  = 1'b1;
          end
          W_VID: begin
            mem_address = {2'b10, vid_addr};
            vid_rdata_d = mem_out;
            last_cpu_d  = 1'b0;
          end
          W_KBD: begin
            mem_address = KBD_REG;
            mem_in      = kbd_code;
            mem_load    = 1'b1;
          end
          default: ;
        endcase
        if (win != W_NONE) begin
          state_d = S_ACK;
          win_d   = win;
          err_d   = (win == W_CPU) && cpu_illegal;
          if (win == W_VID)                          vid_wait_d = '0;
          else if (vid_req && (vid_wait_q != 4'hF))  vid_wait_d = vid_wait_q + 4'd1;
        end
      end
      S_ACK: begin
        cpu_ack = (win_q == W_CPU);
        vid_ack = (win_q == W_VID);
        kbd_ack = (win_q == W_KBD);
        cpu_err = (win_q == W_CPU) && err_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (!vid_req) vid_wait_d = '0;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= S_IDLE;
      win_q       <= W_NONE;
      err_q       <= 1'b0;
      last_cpu_q  <= 1'b0;
      vid_wait_q  <= '0;
      cpu_rdata_q <= '0;
      vid_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      err_q       <= err_d;
      last_cpu_q  <= last_cpu_d;
      vid_wait_q  <= vid_wait_d;
      cpu_rdata_q <= cpu_rdata_d;
      vid_rdata_q <= vid_rdata_d;
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed scenarios plus random requesters, all checked
// against a cycle-level reference model and a shadow copy of the memory map.
module tb_memory_arbiter;
  localparam int VMW = 4;

  logic        CLK = 1'b0, RST_N = 1'b0;
  logic        cpu_req = 0, cpu_we = 0;
  logic [14:0] cpu_addr = '0;
  logic [15:0] cpu_wdata = '0;
  logic        cpu_ack, cpu_err;
  logic [15:0] cpu_rdata;
  logic        vid_req = 0;
  logic [12:0] vid_addr = '0;
  logic        vid_ack;
  logic [15:0] vid_rdata;
  logic        kbd_valid = 0;
  logic [15:0] kbd_code = '0;
  logic        kbd_ack;
  logic [15:0] mem_in, mem_out;
  logic        mem_load;
  logic [14:0] mem_address;

  memory_arbiter #(.VID_MAX_WAIT(VMW)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_rdata(vid_rdata),
    .kbd_valid(kbd_valid), .kbd_code(kbd_code), .kbd_ack(kbd_ack),
    .mem_in(mem_in), .mem_load(mem_load), .mem_address(mem_address), .mem_out(mem_out)
  );

  always #5 CLK = ~CLK;

  // Environment memory seen by the DUT, and the model's independent copy.
  logic [15:0] env_mem [32768];
  logic [15:0] ref_mem [32768];
  assign mem_out = env_mem[mem_address];
  always @(posedge CLK) if (mem_load) env_mem[mem_address] <= mem_in;

  function automatic logic [15:0] initv(int a);
    return 16'((a * 40503) ^ 23130);
  endfunction

  int n_chk = 0, n_pass = 0;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
  endtask

  // Reference model: 0 none, 1 cpu, 2 video, 3 keyboard.
  bit          m_ack = 0, m_err = 0, m_last_cpu = 0;
  int          m_win = 0, m_vw = 0;
  logic [15:0] e_cpu = '0, e_vid = '0;

  initial forever begin
    @(negedge CLK);
    if (!RST_N) begin
      chk("rst_load", mem_load, 0);
      chk("rst_acks", {cpu_ack, vid_ack, kbd_ack, cpu_err}, 0);
      chk("rst_rdata", {cpu_rdata, vid_rdata}, 0);
      m_ack = 0; m_err = 0; m_last_cpu = 0; m_win = 0; m_vw = 0; e_cpu = '0; e_vid = '0;
    end else begin
      chk("cpu_rdata", cpu_rdata, e_cpu);
      chk("vid_rdata", vid_rdata, e_vid);
      if (m_ack) begin
        chk("acks", {cpu_ack, vid_ack, kbd_ack},
            m_win == 1 ? 3'b100 : m_win == 2 ? 3'b010 : 3'b001);
        chk("ack_err", cpu_err, m_win == 1 && m_err);
        chk("ack_load", mem_load, 0);
        m_ack = 0;
      end else begin
        int w;
        bit ill;
        w = 0;
        if (m_vw >= VMW && vid_req)  w = 2;
        else if (kbd_valid)          w = 3;
        else if (cpu_req && vid_req) w = m_last_cpu ? 2 : 1;
        else if (cpu_req)            w = 1;
        else if (vid_req)            w = 2;
        chk("idle_acks", {cpu_ack, vid_ack, kbd_ack}, 0);
        case (w)
          0: chk("idle_drive", {mem_load, mem_address, mem_in}, 0);
          1: begin
            ill = cpu_we && cpu_addr >= 15'h6000;
            chk("cpu_addr", mem_address, cpu_addr);
            chk("cpu_load", mem_load, cpu_we && !ill);
            chk("cpu_in", mem_in, cpu_wdata);
            if (!cpu_we) e_cpu = ref_mem[cpu_addr];
            else if (!ill) ref_mem[cpu_addr] = cpu_wdata;
            m_err = ill; m_last_cpu = 1;
          end
          2: begin
            chk("vid_addr", mem_address, 32'h4000 + vid_addr);
            chk("vid_load", mem_load, 0);
            e_vid = ref_mem[32'h4000 + vid_addr];
            m_last_cpu = 0;
          end
          default: begin
            chk("kbd_drive", {mem_load, mem_address, mem_in}, {1'b1, 15'h6000, kbd_code});
            ref_mem[15'h6000] = kbd_code;
          end
        endcase
        if (w != 0) begin m_ack = 1; m_win = w; end
        if (w == 2) m_vw = 0;
        else if (w != 0 && vid_req && m_vw < 15) m_vw++;
      end
      if (!vid_req) m_vw = 0;
    end
  end

  task automatic drop_all();
    cpu_req = 0; vid_req = 0; kbd_valid = 0;
  endtask

  task automatic do_reset();
    @(posedge CLK); #1;
    RST_N = 0; drop_all();
    @(negedge CLK);
    @(posedge CLK); #1;
    RST_N = 1;
  endtask

  // who: 1 cpu, 2 video, 3 keyboard. Returns cpu_err seen with the ack.
  task automatic xfer(int who, bit we, logic [14:0] addr, logic [15:0] data, output bit err);
    bit got;
    got = 0; err = 0;
    case (who)
      1: begin cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = data; end
      2: begin vid_req = 1; vid_addr = addr[12:0]; end
      default: begin kbd_valid = 1; kbd_code = data; end
    endcase
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge CLK);
      if ((who == 1 && cpu_ack) || (who == 2 && vid_ack) || (who == 3 && kbd_ack)) begin
        got = 1; err = cpu_err;
      end
    end
    chk("ack_timeout", got, 1);
    @(posedge CLK); #1;
    drop_all();
  endtask

  function automatic logic [14:0] rand_addr();
    case ($urandom_range(0, 3))
      0:       return 15'($urandom_range(0, 16'h3FFF));
      1:       return 15'($urandom_range(16'h4000, 16'h5FFF));
      2:       return 15'h6000;
      default: return 15'($urandom_range(16'h6000, 16'h7FFF));
    endcase
  endfunction

  initial begin
    bit err, ca, va, ka;
    int nv, nc, nk, first_v;
    for (int a = 0; a < 32768; a++) begin
      env_mem[a] = initv(a);
      ref_mem[a] = initv(a);
    end
    #1;
    chk("reset_outputs", {cpu_ack, vid_ack, kbd_ack, cpu_err, mem_load}, 0);
    @(posedge CLK); #1;
    RST_N = 1;

    // Write then read back through the CPU port.
    xfer(1, 1, 15'h0010, 16'h1234, err);
    xfer(1, 0, 15'h0010, 16'h0000, err);
    chk("cpu_readback", cpu_rdata, 16'h1234);

    // Keyboard update, then an illegal CPU write over it.
    xfer(3, 0, 15'h0, 16'hBEEF, err);
    xfer(1, 1, 15'h6000, 16'hFFFF, err);
    chk("illegal_err", err, 1);
    xfer(1, 0, 15'h6000, 16'h0000, err);
    chk("kbd_preserved", cpu_rdata, 16'hBEEF);
    chk("legal_err", err, 0);

    // Top of the screen region.
    xfer(2, 0, 15'h1FFF, 16'h0, err);
    chk("vid_top", vid_rdata, initv(16'h5FFF));

    // CPU and video held together: strict alternation.
    do_reset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 15'h0020; vid_req = 1; vid_addr = 13'h5;
    nv = 0; nc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      nv += int'(vid_ack); nc += int'(cpu_ack);
    end
    chk("rr_vid_acks", nv, 10);
    chk("rr_cpu_acks", nc, 10);
    @(posedge CLK); #1; drop_all();

    // Keyboard and video held together: video promoted on the fifth round.
    do_reset();
    kbd_valid = 1; kbd_code = 16'h00A5; vid_req = 1; vid_addr = 13'h40;
    nv = 0; nk = 0; first_v = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (vid_ack && first_v < 0) first_v = i;
      nv += int'(vid_ack);
      if (i < 10) nk += int'(kbd_ack);
    end
    chk("promo_first_vid", first_v, 9);
    chk("promo_kbd_before", nk, 4);
    chk("promo_vid_count", nv, 2);
    @(posedge CLK); #1; drop_all();

    // Reset pulse while the ack is pending.
    @(posedge CLK); #1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 15'h0100;
    @(posedge CLK); #2;
    RST_N = 0;
    #1;
    chk("rst_in_ack", {cpu_ack, cpu_err, mem_load}, 0);
    chk("rst_in_ack_rdata", cpu_rdata, 0);
    cpu_req = 0;
    @(negedge CLK);
    @(posedge CLK); #1;
    RST_N = 1;
    xfer(1, 0, 15'h0010, 16'h0, err);
    chk("resume_read", cpu_rdata, 16'h1234);

    // Random requesters obeying the hold-until-ack protocol.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge CLK);
      ca = cpu_ack; va = vid_ack; ka = kbd_ack;
      @(posedge CLK); #1;
      if (ca || !cpu_req) begin
        cpu_req = ($urandom_range(0, 2) != 0);
        cpu_we = 1'($urandom_range(0, 1)); cpu_addr = rand_addr(); cpu_wdata = 16'($urandom);
      end else if (!(m_ack && m_win == 1) && $urandom_range(0, 15) == 0) cpu_req = 0;
      if (va || !vid_req) begin
        vid_req = ($urandom_range(0, 2) != 0);
        vid_addr = 13'($urandom);
      end else if (!(m_ack && m_win == 2) && $urandom_range(0, 15) == 0) vid_req = 0;
      if (ka || !kbd_valid) begin
        kbd_valid = ($urandom_range(0, 5) == 0);
        kbd_code = 16'($urandom);
      end else if (!(m_ack && m_win == 3) && $urandom_range(0, 15) == 0) kbd_valid = 0;
    end
    drop_all();
    repeat (4) @(posedge CLK);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
